// File: rtl/axis_to_axi4_wr_pkg.sv
// Shared types and AXI constants for the axis_to_axi4_wr write engine.
package axis_to_axi4_wr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    // AxSIZE encoding: log2 of the bytes per beat.
    function automatic logic [2:0] axi_size(input int data_w);
        return 3'($clog2(data_w / 8));
    endfunction

endpackage

// File: rtl/axi4_wr_if.sv
// AXI4 write-channel bundle (AW, W, B) toward memory or an interconnect.
interface axi4_wr_if #(
    parameter int ID_W       = 1,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter     ALIGN_DATA = "NO"
);
    logic                awvalid;
    logic                awready;
    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic                awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic [3:0]          awregion;
    logic                wvalid;
    logic                wready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                bvalid;
    logic                bready;
    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awregion, wvalid, wdata, wstrb, wlast, bready,
        input  awready, wready, bvalid, bid, bresp
    );
    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache,
               awprot, awqos, awregion, wvalid, wdata, wstrb, wlast, bready,
        output awready, wready, bvalid, bid, bresp
    );
endinterface

// File: rtl/axis_if.sv
// AXI-Stream bundle used between stream producers and the write engine.
interface axis_if #(
    parameter int DATA_W = 64
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_W-1:0]     tdata;
    logic [DATA_W/8-1:0]   tkeep;
    logic                  tlast;

    modport master (output tvalid, tdata, tkeep, tlast, input tready);
    modport slave  (input tvalid, tdata, tkeep, tlast, output tready);
endinterface

// File: rtl/axis_to_axi4_wr.sv
// DMA write engine: AXI-Stream in, AXI4 INCR bursts out, one burst outstanding.
// Optional macro AXIS_TO_AXI4_WR_TLAST_TERM_EN: TLAST ends the transfer, padding the burst.
module axis_to_axi4_wr
    import axis_to_axi4_wr_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int ADDR_W    = 32,
    parameter int ID_W      = 1,
    parameter int BURST_LEN = 16
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              cfg_start,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [31:0]       cfg_beats,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       done_beats,
    output state_t            dbg_state,
    axis_if.slave             s_axis,
    axi4_wr_if.master         m_axi
);

    localparam int SIZE_LOG = $clog2(DATA_W / 8);

    // Every channel transfers on a cycle where valid && ready; a raised valid
    // and its payload stay put until that cycle, and ready never gates valid.

    state_t            state;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       rem;
    logic [8:0]        len;
    logic [8:0]        beat_cnt;
    logic              awvalid_q;
    logic [ADDR_W-1:0] awaddr_q;
    logic [7:0]        awlen_q;
    logic              pad;
    logic              in_data;
    logic              w_hs;
    logic [31:0]       rem_next;
    logic [ADDR_W-1:0] addr_next;

    function automatic logic [8:0] burst_beats(input logic [31:0] r);
        if (r > 32'(BURST_LEN))
            return 9'(BURST_LEN);
        return r[8:0];
    endfunction

`ifdef AXIS_TO_AXI4_WR_TLAST_TERM_EN
    logic term_q;
    assign pad = term_q;
`else
    assign pad = 1'b0;
`endif

    assign in_data   = (state == DATA);
    assign rem_next  = rem - 32'(len);
    assign addr_next = cur_addr + (ADDR_W'(len) << SIZE_LOG);

    // Zero-latency pass-through in DATA; pad beats come from the engine itself.
    assign m_axi.wvalid  = in_data && (pad || s_axis.tvalid);
    assign s_axis.tready = in_data && !pad && m_axi.wready;
    assign m_axi.wdata   = pad ? '0 : s_axis.tdata;
    assign m_axi.wstrb   = pad ? '0 : s_axis.tkeep;
    assign m_axi.wlast   = in_data && (beat_cnt == len - 9'd1);
    assign w_hs          = m_axi.wvalid && m_axi.wready;
    assign m_axi.bready  = (state == RESP);

    assign m_axi.awvalid  = awvalid_q;
    assign m_axi.awaddr   = awaddr_q;
    assign m_axi.awlen    = awlen_q;
    assign m_axi.awid     = '0;
    assign m_axi.awsize   = axi_size(DATA_W);
    assign m_axi.awburst  = BURST_INCR;
    assign m_axi.awlock   = 1'b0;
    assign m_axi.awcache  = CACHE_DEFAULT;
    assign m_axi.awprot   = 3'b000;
    assign m_axi.awqos    = 4'b0000;
    assign m_axi.awregion = 4'b0000;

    assign dbg_state = state;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            cur_addr   <= '0;
            rem        <= '0;
            len        <= '0;
            beat_cnt   <= '0;
            awvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            awlen_q    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            done_beats <= '0;
`ifdef AXIS_TO_AXI4_WR_TLAST_TERM_EN
            term_q     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        cur_addr   <= cfg_addr;
                        rem        <= cfg_beats;
                        err        <= 1'b0;
                        done_beats <= '0;
`ifdef AXIS_TO_AXI4_WR_TLAST_TERM_EN
                        term_q     <= 1'b0;
`endif
                        if (cfg_beats == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            state     <= ADDR;
                            awvalid_q <= 1'b1;
                            awaddr_q  <= cfg_addr;
                            awlen_q   <= 8'(burst_beats(cfg_beats) - 9'd1);
                        end
                    end
                end
                ADDR: begin
                    if (m_axi.awready) begin
                        awvalid_q <= 1'b0;
                        len       <= {1'b0, awlen_q} + 9'd1;
                        beat_cnt  <= '0;
                        state     <= DATA;
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 9'd1;
                        if (!pad)
                            done_beats <= done_beats + 32'd1;
`ifdef AXIS_TO_AXI4_WR_TLAST_TERM_EN
                        if (!pad && s_axis.tlast)
                            term_q <= 1'b1;
`endif
                        if (m_axi.wlast)
                            state <= RESP;
                    end
                end
                RESP: begin
                    if (m_axi.bvalid) begin
                        if (m_axi.bresp != RESP_OKAY)
                            err <= 1'b1;
                        rem      <= rem_next;
                        cur_addr <= addr_next;
                        if (rem_next == 32'd0 || pad) begin
                            state <= IDLE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= ADDR;
                            awvalid_q <= 1'b1;
                            awaddr_q  <= addr_next;
                            awlen_q   <= 8'(burst_beats(rem_next) - 9'd1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axis_to_axi4_wr.sv
// Directed-sequence bench for axis_to_axi4_wr with a random-stall AXI slave and stream source.
module tb_axis_to_axi4_wr;
  import axis_to_axi4_wr_pkg::*;

  localparam int DW = 64;
  localparam int AW = 32;
  localparam int BL = 16;
  localparam int SW = DW / 8;
  localparam int EW = 2 + SW + DW;  // {pad, last, keep, data}

  logic          ACLK = 1'b0;
  logic          ARESETn = 1'b0;
  logic          cfg_start = 1'b0;
  logic [AW-1:0] cfg_addr = '0;
  logic [31:0]   cfg_beats = '0;
  logic          busy, done, err;
  logic [31:0]   done_beats;
  state_t        dbg_state;

  axis_if #(.DATA_W(DW)) s_axis ();
  axi4_wr_if #(.ID_W(1), .ADDR_W(AW), .DATA_W(DW), .ALIGN_DATA("NO")) m_axi ();

  axis_to_axi4_wr #(.DATA_W(DW), .ADDR_W(AW), .ID_W(1), .BURST_LEN(BL)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .cfg_start(cfg_start), .cfg_addr(cfg_addr),
    .cfg_beats(cfg_beats), .busy(busy), .done(done), .err(err), .done_beats(done_beats),
    .dbg_state(dbg_state), .s_axis(s_axis), .m_axi(m_axi)
  );

  // clock / reset
  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0]   exp_q[$];
  logic [AW+7:0]   exp_aw_q[$];
  logic [SW+DW:0]  src_q[$];   // {tlast, keep, data}
  logic [1:0]      bresp_q[$];
  bit rand_stall = 0;
  bit activity = 0;
  bit outstanding = 0;
  bit b_pend = 0;
  int done_cnt = 0;
  int bursts_done = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fail_now(input string tag);
    n_cmp++;
    n_bad++;
    $error("FAIL %s: observed event not expected", tag);
  endtask

  // Expected transfer derived from address/beat count: bursts of BL beats, last one shorter.
  task automatic build(input logic [AW-1:0] addr, input int beats, input int bad);
    int n;
    for (int b = 0; b < beats; b++) begin
      logic [DW-1:0] d;
      logic [SW-1:0] k;
      bit last;
      d = {$urandom, $urandom};
      k = SW'($urandom_range(1, 255));
      last = ((b + 1) % BL == 0) || (b + 1 == beats);
      src_q.push_back({1'b0, k, d});
      exp_q.push_back({1'b0, last, k, d});
    end
    n = 0;
    for (int off = 0; off < beats; off += BL) begin
      int l;
      l = (beats - off < BL) ? beats - off : BL;
      exp_aw_q.push_back({addr + AW'(off * SW), 8'(l - 1)});
      bresp_q.push_back(n == bad ? 2'b10 : 2'b00);
      n++;
    end
  endtask

  // driver tasks
  task automatic start(input logic [AW-1:0] addr, input logic [31:0] beats);
    @(posedge ACLK); #1;
    cfg_addr = addr;
    cfg_beats = beats;
    cfg_start = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int base, input int max);
    int c;
    c = 0;
    while (done_cnt == base && c < max) begin
      @(negedge ACLK); #1;
      c++;
    end
    if (done_cnt == base) fail_now("done_timeout");
  endtask

  task automatic check_end(input string tag, input logic [31:0] beats, input logic exp_err, input int base);
    chk({tag, "_done_beats"}, done_beats, beats);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_queues_empty"}, {exp_q.size() == 0, exp_aw_q.size() == 0}, 2'b11);
    repeat (3) @(negedge ACLK);
    #1;
    chk({tag, "_done_once"}, done_cnt, base + 1);
  endtask

  // AXI slave, stream source and monitors / scoreboard
  initial begin : bus_model
    bit t_pop, aw_stall_prev, err_chk;
    logic [AW+7:0] aw_hold;
    logic [EW-1:0] e;
    s_axis.tvalid = 0; s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 0;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 2'b00; m_axi.bid = '0;
    t_pop = 0; aw_stall_prev = 0; err_chk = 0; aw_hold = '0;
    forever begin
      @(negedge ACLK);
      if (!ARESETn) begin
        s_axis.tvalid = 0; m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
        t_pop = 0; aw_stall_prev = 0; err_chk = 0; outstanding = 0; b_pend = 0;
        continue;
      end
      if (err_chk) chk("err_after_bad_b", err, 1'b1);
      err_chk = 0;
      if (m_axi.awvalid || m_axi.wvalid || s_axis.tready) activity = 1;
      if (aw_stall_prev && m_axi.awvalid) chk("aw_stable", {m_axi.awaddr, m_axi.awlen}, aw_hold);
      aw_stall_prev = m_axi.awvalid && !m_axi.awready;
      aw_hold = {m_axi.awaddr, m_axi.awlen};
      if (m_axi.awvalid && m_axi.awready) begin
        chk("aw_single_outstanding", outstanding, 1'b0);
        outstanding = 1;
        chk("aw_const", {m_axi.awid, m_axi.awsize, m_axi.awburst, m_axi.awlock, m_axi.awcache,
                         m_axi.awprot, m_axi.awqos, m_axi.awregion},
            {1'b0, 3'($clog2(SW)), 2'b01, 1'b0, 4'b0011, 3'b000, 4'b0000, 4'b0000});
        if (exp_aw_q.size() == 0) fail_now("aw_unexpected");
        else chk("aw_addr_len", {m_axi.awaddr, m_axi.awlen}, exp_aw_q.pop_front());
      end
      if (m_axi.wvalid && m_axi.wready) begin
        if (exp_q.size() == 0) fail_now("w_unexpected");
        else begin
          e = exp_q.pop_front();
          if (e[EW-1]) chk("w_pad", {m_axi.wlast, m_axi.wstrb}, {e[EW-2], SW'(0)});
          else chk("w_beat", {m_axi.wlast, m_axi.wstrb, m_axi.wdata}, e[EW-2:0]);
        end
        if (m_axi.wlast) b_pend = 1;
      end
      t_pop = s_axis.tvalid && s_axis.tready;
      if (m_axi.bvalid && m_axi.bready) begin
        b_pend = 0;
        outstanding = 0;
        bursts_done++;
        if (m_axi.bresp != 2'b00) err_chk = 1;
        if (bresp_q.size() > 0) void'(bresp_q.pop_front());
      end
      if (done) done_cnt++;

      @(posedge ACLK); #1;
      if (!ARESETn) continue;
      if (t_pop && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        if (!(s_axis.tvalid && !t_pop))
          s_axis.tvalid = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        {s_axis.tlast, s_axis.tkeep, s_axis.tdata} = src_q[0];
      end else begin
        s_axis.tvalid = 0;
      end
      m_axi.awready = rand_stall ? ($urandom_range(0, 2) == 0) : 1'b1;
      m_axi.wready  = rand_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (b_pend) begin
        if (!m_axi.bvalid) m_axi.bvalid = rand_stall ? ($urandom_range(0, 1) == 1) : 1'b1;
        m_axi.bresp = (bresp_q.size() > 0) ? bresp_q[0] : 2'b00;
      end else begin
        m_axi.bvalid = 0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int base, c, bb;
    #12;
    chk("rst_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, s_axis.tready}, 4'b0);
    chk("rst_status", {busy, done, err}, 3'b0);
    chk("rst_done_beats", done_beats, 32'd0);
    chk("rst_state", dbg_state, IDLE);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // multi-burst split, no stalls
    base = done_cnt;
    build(32'h1000, 40, -1);
    start(32'h1000, 40);
    @(negedge ACLK); #1;
    chk("mb_busy", busy, 1'b1);
    chk("mb_awvalid", m_axi.awvalid, 1'b1);
    wait_done(base, 1000);
    check_end("mb", 32'd40, 1'b0, base);

    // zero-length transfer
    activity = 0;
    base = done_cnt;
    start(32'h1000, 0);
    @(negedge ACLK); #1;
    chk("zero_done", done, 1'b1);
    chk("zero_busy", busy, 1'b0);
    @(negedge ACLK); #1;
    chk("zero_done_pulse", done, 1'b0);
    repeat (5) @(negedge ACLK);
    #1;
    chk("zero_no_activity", activity, 1'b0);
    chk("zero_done_once", done_cnt, base + 1);

    // backpressure everywhere, 33 beats ending in a single-beat burst
    rand_stall = 1;
    base = done_cnt;
    build(32'h2000, 33, -1);
    start(32'h2000, 33);
    wait_done(base, 5000);
    check_end("bp", 32'd33, 1'b0, base);

    // error on burst 2 of 3, plus a start while busy that must be ignored
    rand_stall = 0;
    base = done_cnt;
    build(32'h4000, 40, 1);
    start(32'h4000, 40);
    start(32'h9000, 5);
    wait_done(base, 1000);
    check_end("errb", 32'd40, 1'b1, base);
    base = done_cnt;
    build(32'h5000, 3, -1);
    start(32'h5000, 3);
    @(negedge ACLK); #1;
    chk("err_cleared_on_start", err, 1'b0);
    chk("done_beats_cleared", done_beats, 32'd0);
    wait_done(base, 1000);
    check_end("small", 32'd3, 1'b0, base);

    // reset mid-DATA of the second burst, after an error on the first
    bb = bursts_done;
    build(32'h6000, 40, 0);
    start(32'h6000, 40);
    c = 0;
    while (!(bursts_done > bb && m_axi.wvalid) && c < 500) begin
      @(negedge ACLK); #1;
      c++;
    end
    if (c >= 500) fail_now("rst_wait_timeout");
    chk("err_before_rst", err, 1'b1);
    #1;
    ARESETn = 1'b0;
    #1;
    chk("rst_async_valids", {m_axi.awvalid, m_axi.wvalid, m_axi.bready, s_axis.tready}, 4'b0);
    chk("rst_async_status", {busy, done, err}, 3'b0);
    chk("rst_async_state", dbg_state, IDLE);
    exp_q.delete(); exp_aw_q.delete(); src_q.delete(); bresp_q.delete();
    repeat (2) @(negedge ACLK);
    #2;
    ARESETn = 1'b1;

    // recovery after reset
    rand_stall = 1;
    base = done_cnt;
    build(32'h7000, 17, -1);
    start(32'h7000, 17);
    wait_done(base, 5000);
    check_end("recov", 32'd17, 1'b0, base);

`ifdef AXIS_TO_AXI4_WR_TLAST_TERM_EN
    // TLAST on beat 20 of 40: pads fill burst 2, no third burst
    rand_stall = 0;
    base = done_cnt;
    for (int b = 0; b < 40; b++) begin
      logic [DW-1:0] d;
      logic [SW-1:0] k;
      d = {$urandom, $urandom};
      k = SW'($urandom_range(1, 255));
      src_q.push_back({(b == 19), k, d});
      if (b < 20) exp_q.push_back({1'b0, ((b + 1) % BL == 0), k, d});
    end
    for (int b = 20; b < 32; b++) exp_q.push_back({1'b1, (b == 31), SW'(0), DW'(0)});
    exp_aw_q.push_back({32'h8000, 8'd15});
    exp_aw_q.push_back({32'h8080, 8'd15});
    bresp_q.push_back(2'b00);
    bresp_q.push_back(2'b00);
    start(32'h8000, 40);
    wait_done(base, 1000);
    check_end("tlast", 32'd20, 1'b0, base);
    src_q.delete();
`endif

    repeat (3) @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
